// File: rtl/definitions.sv
// Shared types for the MISC host-side program loader.
//   BYTE           : one stream/instruction byte.
//   loader_state_t : loader FSM states.
package definitions;

    typedef logic [7:0] BYTE;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMMIT,
        RUN,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset to zero
//   clear  : synchronous clear to zero (takes priority over enable)
//   enable : count up by one this cycle
//   count  : current (registered) count value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // NOTE: registered state is always assigned with <= so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Host-side front end of the MISC core. It takes a program as a byte
// stream over a valid/ready handshake, writes it into instruction memory
// from address 0, then releases the core from reset and counts execution
// cycles until the core reports done.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : one-cycle request to begin a new load
//   s_valid/s_data/s_last: program byte stream (s_last marks final byte)
//   s_ready              : loader accepts a byte this cycle
//   imem_we/addr/wdata   : instruction-memory write port
//   core_reset           : drives MISC reset (held high except in RUN)
//   core_done            : MISC done, only observed in RUN
//   loaded_len           : bytes written by the last load
//   cycle_count          : RUN cycles before done (saturating)
//   finished             : program halted normally
//   error                : program overflowed memory before s_last
module program_loader
    import definitions::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int CYC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_reset,
    input  logic                  core_done,
    output logic [ADDR_WIDTH:0]   loaded_len,
    output logic [CYC_WIDTH-1:0]  cycle_count,
    output logic                  finished,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    loader_state_t         state;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  start_accept;
    logic                  cnt_enable;
    logic                  handshake;

    // start is honoured only where a new load may begin.
    assign start_accept = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign cnt_enable   = (state == RUN) && !core_done;
    assign handshake    = s_valid && s_ready;

    sat_counter #(
        .WIDTH (CYC_WIDTH)
    ) u_cycle_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_accept),
        .enable (cnt_enable),
        .count  (cycle_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: instruction memory lives outside this block and is
            // deliberately not cleared; only control state is reset.
            state      <= IDLE;
            wr_addr    <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            loaded_len <= '0;
            finished   <= 1'b0;
            error      <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted byte.
            imem_we <= 1'b0;

            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state      <= LOAD;
                        s_ready    <= 1'b1;
                        wr_addr    <= '0;
                        loaded_len <= '0;
                        finished   <= 1'b0;
                        error      <= 1'b0;
                    end
                end

                LOAD: begin
                    if (handshake) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= wr_addr;
                        imem_wdata <= s_data;
                        wr_addr    <= wr_addr + 1'b1;
                        // One bit wider than the address so a full
                        // memory reports N rather than wrapping to 0.
                        loaded_len <= {1'b0, wr_addr} + 1'b1;
                        if (s_last) begin
                            state   <= COMMIT;
                            s_ready <= 1'b0;
                        end else if (wr_addr == LAST_ADDR) begin
                            state   <= ERROR;
                            s_ready <= 1'b0;
                            error   <= 1'b1;
                        end
                    end
                end

                // The final byte's write strobe is on the bus this cycle;
                // the core leaves reset only once it has landed.
                COMMIT: begin
                    state      <= RUN;
                    core_reset <= 1'b0;
                end

                RUN: begin
                    if (core_done) begin
                        state      <= DONE;
                        core_reset <= 1'b1;
                        finished   <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    s_ready    <= 1'b0;
                    core_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Instance a uses default parameters;
// instance b uses ADDR_WIDTH=2, CYC_WIDTH=4 for overflow, exact-fit and
// saturation cases. Inputs change and outputs are sampled on the falling
// edge, so every check sees the state left by the preceding rising edge.
module tb_program_loader;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: ADDR_WIDTH=10, CYC_WIDTH=32
    logic        a_reset, a_start, a_s_valid, a_s_last, a_s_ready;
    logic [7:0]  a_s_data, a_imem_wdata;
    logic        a_imem_we, a_core_reset, a_core_done, a_finished, a_error;
    logic [9:0]  a_imem_addr;
    logic [10:0] a_loaded_len;
    logic [31:0] a_cycle_count;

    // Instance b: ADDR_WIDTH=2, CYC_WIDTH=4
    logic        b_reset, b_start, b_s_valid, b_s_last, b_s_ready;
    logic [7:0]  b_s_data, b_imem_wdata;
    logic        b_imem_we, b_core_reset, b_core_done, b_finished, b_error;
    logic [1:0]  b_imem_addr;
    logic [2:0]  b_loaded_len;
    logic [3:0]  b_cycle_count;

    program_loader u_dut_a (
        .clk         (clk),
        .reset       (a_reset),
        .start       (a_start),
        .s_valid     (a_s_valid),
        .s_data      (a_s_data),
        .s_last      (a_s_last),
        .s_ready     (a_s_ready),
        .imem_we     (a_imem_we),
        .imem_addr   (a_imem_addr),
        .imem_wdata  (a_imem_wdata),
        .core_reset  (a_core_reset),
        .core_done   (a_core_done),
        .loaded_len  (a_loaded_len),
        .cycle_count (a_cycle_count),
        .finished    (a_finished),
        .error       (a_error)
    );

    program_loader #(
        .ADDR_WIDTH (2),
        .DATA_WIDTH (8),
        .CYC_WIDTH  (4)
    ) u_dut_b (
        .clk         (clk),
        .reset       (b_reset),
        .start       (b_start),
        .s_valid     (b_s_valid),
        .s_data      (b_s_data),
        .s_last      (b_s_last),
        .s_ready     (b_s_ready),
        .imem_we     (b_imem_we),
        .imem_addr   (b_imem_addr),
        .imem_wdata  (b_imem_wdata),
        .core_reset  (b_core_reset),
        .core_done   (b_core_done),
        .loaded_len  (b_loaded_len),
        .cycle_count (b_cycle_count),
        .finished    (b_finished),
        .error       (b_error)
    );

    // Instruction-memory models fed by the write ports.
    logic [7:0] a_mem [0:1023];
    logic [7:0] b_mem [0:3];
    int         a_wr_count = 0;
    int         b_wr_count = 0;

    always @(posedge clk) begin
        if (a_imem_we) begin
            a_mem[a_imem_addr] <= a_imem_wdata;
            a_wr_count         <= a_wr_count + 1;
        end
        if (b_imem_we) begin
            b_mem[b_imem_addr] <= b_imem_wdata;
            b_wr_count         <= b_wr_count + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bytes [0:2];
        int         gaps  [0:2];
        int         base;

        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        gaps[0]  = 0;     gaps[1]  = 2;     gaps[2]  = 1;

        a_reset = 1'b1; a_start = 1'b0; a_s_valid = 1'b0; a_s_data = '0;
        a_s_last = 1'b0; a_core_done = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_s_valid = 1'b0; b_s_data = '0;
        b_s_last = 1'b0; b_core_done = 1'b0;

        // ---------------- reset values ----------------
        repeat (2) tick();
        check("rst_core_reset", a_core_reset, 1);
        check("rst_s_ready",    a_s_ready,    0);
        check("rst_imem_we",    a_imem_we,    0);
        check("rst_imem_addr",  a_imem_addr,  0);
        check("rst_imem_wdata", a_imem_wdata, 0);
        check("rst_loaded_len", a_loaded_len, 0);
        check("rst_cycle_cnt",  a_cycle_count, 0);
        check("rst_finished",   a_finished,   0);
        check("rst_error",      a_error,      0);
        check("rst_b_core_rst", b_core_reset, 1);
        a_reset = 1'b0;
        b_reset = 1'b0;
        tick();
        check("idle_s_ready", a_s_ready, 0);

        // ---------------- back-to-back load ----------------
        a_start = 1'b1;
        tick();
        check("b2b_start_ready", a_s_ready, 1);
        a_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_s_valid = 1'b1;
            a_s_data  = bytes[i];
            a_s_last  = (i == 2);
            tick();
            check($sformatf("b2b_we%0d", i),    a_imem_we,    1);
            check($sformatf("b2b_addr%0d", i),  a_imem_addr,  i);
            check($sformatf("b2b_wdata%0d", i), a_imem_wdata, bytes[i]);
        end
        a_s_valid = 1'b0;
        a_s_last  = 1'b0;
        check("b2b_ready_after_last", a_s_ready,    0);
        check("b2b_loaded_len",       a_loaded_len, 3);
        check("b2b_core_rst_commit",  a_core_reset, 1);
        tick();
        check("b2b_core_rst_run", a_core_reset, 0);
        check("b2b_we_low_run",   a_imem_we,    0);
        check("b2b_mem0", a_mem[0], 8'h11);
        check("b2b_mem1", a_mem[1], 8'h22);
        check("b2b_mem2", a_mem[2], 8'h33);
        repeat (5) tick();
        a_core_done = 1'b1;
        tick();
        a_core_done = 1'b0;
        check("b2b_cycle_count", a_cycle_count, 5);
        check("b2b_finished",    a_finished,    1);
        check("b2b_core_rst_dn", a_core_reset,  1);

        // ---------------- gapped stream ----------------
        base    = a_wr_count;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("gap_finished_clr", a_finished, 0);
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                a_s_valid = 1'b0;
                tick();
                check($sformatf("gap_we_low%0d_%0d", i, g), a_imem_we, 0);
            end
            a_s_valid = 1'b1;
            a_s_data  = bytes[i];
            a_s_last  = (i == 2);
            tick();
            check($sformatf("gap_addr%0d", i),  a_imem_addr,  i);
            check($sformatf("gap_wdata%0d", i), a_imem_wdata, bytes[i]);
        end
        a_s_valid = 1'b0;
        a_s_last  = 1'b0;
        check("gap_loaded_len", a_loaded_len, 3);
        tick();
        check("gap_writes", a_wr_count - base, 3);
        check("gap_mem0", a_mem[0], 8'h11);
        check("gap_mem1", a_mem[1], 8'h22);
        check("gap_mem2", a_mem[2], 8'h33);
        a_core_done = 1'b1;
        tick();
        a_core_done = 1'b0;
        check("gap_cycle_count", a_cycle_count, 0);
        check("gap_finished",    a_finished,    1);

        // ---------------- reset mid-run, start ignored in RUN ----------------
        a_start = 1'b1;
        tick();
        a_start   = 1'b0;
        a_s_valid = 1'b1;
        a_s_data  = 8'h44;
        a_s_last  = 1'b1;
        tick();
        a_s_valid = 1'b0;
        a_s_last  = 1'b0;
        tick();
        repeat (3) tick();
        check("mid_cycle_count", a_cycle_count, 3);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("run_start_ignored_ready", a_s_ready,     0);
        check("run_start_ignored_crst",  a_core_reset,  0);
        check("run_start_ignored_count", a_cycle_count, 4);
        check("run_start_loaded_len",    a_loaded_len,  1);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        check("mid_rst_core_reset", a_core_reset,  1);
        check("mid_rst_cycle_cnt",  a_cycle_count, 0);
        check("mid_rst_loaded_len", a_loaded_len,  0);
        check("mid_rst_s_ready",    a_s_ready,     0);
        tick();
        check("mid_rst_stays_idle", a_s_ready, 0);

        // ---------------- overflow (N=4) ----------------
        base    = b_wr_count;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("ovf_start_ready", b_s_ready, 1);
        for (int i = 0; i < 5; i++) begin
            b_s_valid = 1'b1;
            b_s_data  = 8'hA0 + 8'(i);
            tick();
            if (i < 4) begin
                check($sformatf("ovf_addr%0d", i),  b_imem_addr,  i);
                check($sformatf("ovf_wdata%0d", i), b_imem_wdata, 8'hA0 + i);
            end else begin
                check("ovf_5th_not_written", b_imem_we, 0);
            end
            if (i == 3) begin
                check("ovf_ready_low", b_s_ready, 0);
                check("ovf_error",     b_error,   1);
            end
        end
        b_s_valid = 1'b0;
        check("ovf_write_count", b_wr_count - base, 4);
        check("ovf_mem3",        b_mem[3],          8'hA3);
        check("ovf_loaded_len",  b_loaded_len,      4);
        check("ovf_core_reset",  b_core_reset,      1);
        check("ovf_finished",    b_finished,        0);

        // ---------------- exact fit (N=4) ----------------
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("fit_error_clr", b_error,   0);
        check("fit_ready",     b_s_ready, 1);
        for (int i = 0; i < 4; i++) begin
            b_s_valid = 1'b1;
            b_s_data  = 8'hB0 + 8'(i);
            b_s_last  = (i == 3);
            tick();
        end
        b_s_valid = 1'b0;
        b_s_last  = 1'b0;
        check("fit_loaded_len", b_loaded_len, 4);
        check("fit_error",      b_error,      0);
        check("fit_ready_low",  b_s_ready,    0);
        tick();
        check("fit_run_core_reset", b_core_reset, 0);
        check("fit_mem3",           b_mem[3],     8'hB3);

        // ---------------- saturation and restart ----------------
        repeat (20) tick();
        b_core_done = 1'b1;
        tick();
        b_core_done = 1'b0;
        check("sat_cycle_count", b_cycle_count, 15);
        check("sat_finished",    b_finished,    1);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("restart_finished",    b_finished,    0);
        check("restart_cycle_count", b_cycle_count, 0);
        check("restart_loaded_len",  b_loaded_len,  0);
        check("restart_ready",       b_s_ready,     1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
